pq_traffic_gen: RTL and testbench

//  Synthesizable initiator for the priority-queue read interface: drives enq/deq/kvi into any PQ

---
 rtl/pq_traffic_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_pq_traffic_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_traffic_gen.sv
// pq_traffic_gen: self-test initiator for a priority-queue device; runs fill -> mixed -> drain
// with LFSR keys and counts check failures. Define PQ_TG_VALUE_CHECK_EN to enable the key/value tag check.
module pq_traffic_gen #(
  parameter int               KEY_W     = 8,
  parameter int               VAL_W     = 8,
  parameter int               PQ_DEPTH  = 16,
  parameter logic [KEY_W-1:0] LFSR_SEED = KEY_W'(8'hA5),
  parameter bit               MIN_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [15:0]      i_num_mix,
  output logic             o_done,
  output logic [15:0]      o_err_count,
  output logic             o_enq,
  output logic             o_deq,
  output logic [KEY_W-1:0] o_kvi_key,
  output logic [VAL_W-1:0] o_kvi_val,
  input  logic [KEY_W-1:0] i_kvo_key,
  input  logic [VAL_W-1:0] i_kvo_val,
  input  logic             i_busy,
  input  logic             i_full,
  input  logic             i_empty
);

  localparam int               OCC_W    = $clog2(PQ_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(PQ_DEPTH);
  localparam logic [OCC_W-1:0] OCC_HALF = OCC_W'(PQ_DEPTH / 2);

  // Right-shift Galois masks for maximal-length sequences; the table covers widths 3..16.
  function automatic logic [31:0] tapsFor(input int w);
    case (w)
      3:       return 32'h0006;
      4:       return 32'h000C;
      5:       return 32'h0014;
      6:       return 32'h0030;
      7:       return 32'h0060;
      8:       return 32'h00B8;
      9:       return 32'h0110;
      10:      return 32'h0240;
      11:      return 32'h0500;
      12:      return 32'h0829;
      13:      return 32'h100D;
      14:      return 32'h2015;
      15:      return 32'h6000;
      16:      return 32'hD008;
      default: return (32'h1 << (w - 1)) | 32'h1;
    endcase
  endfunction

  localparam logic [KEY_W-1:0] LFSR_TAPS = KEY_W'(tapsFor(KEY_W));

`ifdef PQ_TG_VALUE_CHECK_EN
  localparam int TAG_REP = VAL_W / KEY_W + 2;

  function automatic logic [VAL_W-1:0] tagOf(input logic [KEY_W-1:0] k);
    logic [TAG_REP*KEY_W-1:0] rep;
    rep = {TAG_REP{k}};
    return rep[VAL_W-1:0];
  endfunction
`endif

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MIX, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic             r_enq;
  logic             r_deq;
  logic [KEY_W-1:0] r_kviKey;
  logic [VAL_W-1:0] r_kviVal;
  logic             r_done;
  logic [15:0]      r_err;
  logic [OCC_W-1:0] r_occ;
  logic [KEY_W-1:0] r_lfsr;
  logic [15:0]      r_mixCnt;
  logic [15:0]      r_numMix;
  logic [KEY_W-1:0] r_prevKey;
  logic             r_havePrev;

  logic             w_noFlight;
  logic             w_active;
  logic             w_occZero;
  logic [KEY_W-1:0] w_lfsrNext;
  logic             w_opEnq;
  logic             w_opDeq;
  logic             w_outranks;
  logic             w_c1;
  logic             w_c2;
  logic             w_c3;
  logic             w_c4;
  logic [2:0]       w_failCnt;
  logic [16:0]      w_errSum;
  logic [15:0]      w_errNext;
  logic [VAL_W-1:0] w_enqVal;

  // Ops are spaced so the PQ has absorbed the previous one before the next decision or check.
  assign w_noFlight = !(r_enq || r_deq);
  assign w_active   = (r_state == S_FILL) || (r_state == S_MIX) || (r_state == S_DRAIN);
  assign w_occZero  = (r_occ == '0);
  assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

  always_comb begin
    w_opEnq = 1'b0;
    w_opDeq = 1'b0;
    if (w_noFlight && !i_busy) begin
      case (r_state)
        S_FILL:  w_opEnq = (r_occ != OCC_HALF);
        S_MIX: begin
          if (r_mixCnt != r_numMix) begin
            if (r_occ == OCC_FULL) begin
              w_opDeq = 1'b1;
            end else if (w_occZero) begin
              w_opEnq = 1'b1;
            end else begin
              case (r_lfsr[1:0])
                2'b10:   w_opDeq = 1'b1;
                2'b11: begin
                  w_opEnq = 1'b1;
                  w_opDeq = 1'b1;
                end
                default: w_opEnq = 1'b1;
              endcase
            end
          end
        end
        S_DRAIN: w_opDeq = !w_occZero;
        default: ;
      endcase
    end
  end

  assign w_outranks = MIN_FIRST ? (i_kvo_key < r_prevKey) : (i_kvo_key > r_prevKey);

  assign w_c1 = w_active && w_noFlight && (i_empty != w_occZero);
  assign w_c2 = w_active && w_noFlight && (i_full != (r_occ == OCC_FULL));
  assign w_c3 = (r_state == S_DRAIN) && w_opDeq && r_havePrev && w_outranks;

`ifdef PQ_TG_VALUE_CHECK_EN
  assign w_c4     = w_opDeq && (i_kvo_val != tagOf(i_kvo_key));
  assign w_enqVal = tagOf(r_lfsr);
`else
  logic w_unusedVal;
  assign w_unusedVal = ^i_kvo_val;
  assign w_c4        = 1'b0;
  assign w_enqVal    = '0;
`endif

  // Several checks can fail in one cycle; each adds one, saturating at all-ones.
  assign w_failCnt = 3'(w_c1) + 3'(w_c2) + 3'(w_c3) + 3'(w_c4);
  assign w_errSum  = {1'b0, r_err} + 17'(w_failCnt);
  assign w_errNext = w_errSum[16] ? 16'hFFFF : w_errSum[15:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_enq      <= 1'b0;
      r_deq      <= 1'b0;
      r_kviKey   <= '0;
      r_kviVal   <= '0;
      r_done     <= 1'b0;
      r_err      <= '0;
      r_occ      <= '0;
      r_lfsr     <= LFSR_SEED;
      r_mixCnt   <= '0;
      r_numMix   <= '0;
      r_prevKey  <= '0;
      r_havePrev <= 1'b0;
    end else begin
      r_enq <= w_opEnq;
      r_deq <= w_opDeq;
      r_err <= w_errNext;
      if (w_opEnq) begin
        r_kviKey <= r_lfsr;
        r_kviVal <= w_enqVal;
        r_lfsr   <= w_lfsrNext;
      end
      if (w_opEnq && !w_opDeq) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_opDeq && !w_opEnq) begin
        r_occ <= r_occ - 1'b1;
      end
      if ((r_state == S_MIX) && (w_opEnq || w_opDeq)) begin
        r_mixCnt <= r_mixCnt + 16'd1;
      end
      if ((r_state == S_DRAIN) && w_opDeq) begin
        r_prevKey  <= i_kvo_key;
        r_havePrev <= 1'b1;
      end
      // Start overrides the generic updates above since it restarts the whole run.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state    <= S_FILL;
            r_done     <= 1'b0;
            r_err      <= '0;
            r_occ      <= '0;
            r_mixCnt   <= '0;
            r_numMix   <= i_num_mix;
            r_lfsr     <= LFSR_SEED;
            r_havePrev <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_noFlight && (r_occ == OCC_HALF)) begin
            r_state <= (r_numMix == 16'd0) ? S_DRAIN : S_MIX;
          end
        end
        S_MIX: begin
          if (w_noFlight && (r_mixCnt == r_numMix)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_noFlight && w_occZero) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_done      = r_done;
  assign o_err_count = r_err;
  assign o_enq       = r_enq;
  assign o_deq       = r_deq;
  assign o_kvi_key   = r_kviKey;
  assign o_kvi_val   = r_kviVal;

endmodule

// File: tb/tb_pq_traffic_gen.sv
// tb_pq_traffic_gen: drives pq_traffic_gen against a behavioural priority queue (largest key first)
// whose faults can be switched on per run.
module tb_pq_traffic_gen;

  localparam int DEPTH = 16;
`ifdef PQ_TG_VALUE_CHECK_EN
  localparam bit VALUE_CHECK = 1'b1;
`else
  localparam bit VALUE_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] numMix = 16'd0;
  logic        busy = 1'b0;
  logic        done;
  logic [15:0] errCount;
  logic        enq;
  logic        deq;
  logic [7:0]  kviKey;
  logic [7:0]  kviVal;
  logic [7:0]  kvoKey;
  logic [7:0]  kvoVal;
  logic        full;
  logic        empty;

  int testsRun = 0;
  int testsFailed = 0;

  bit injectOrder = 1'b0;
  bit flipVal = 1'b0;
  bit stuckNotEmpty = 1'b0;

  logic [7:0] mKey [DEPTH];
  logic [7:0] mVal [DEPTH];
  logic [4:0] mCount;
  int         deqNum;
  logic [3:0] bestIdx;
  logic [3:0] secondIdx;
  logic [3:0] popIdx;

  pq_traffic_gen dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_num_mix   (numMix),
    .o_done      (done),
    .o_err_count (errCount),
    .o_enq       (enq),
    .o_deq       (deq),
    .o_kvi_key   (kviKey),
    .o_kvi_val   (kviVal),
    .i_kvo_key   (kvoKey),
    .i_kvo_val   (kvoVal),
    .i_busy      (busy),
    .i_full      (full),
    .i_empty     (empty)
  );

  always #5 clk = ~clk;

  // Head selection; the third pop of a run can be redirected to the runner-up to break ordering.
  always_comb begin
    bestIdx = 4'd0;
    for (int i = 1; i < DEPTH; i++) begin
      if (i < int'(mCount) && mKey[4'(i)] > mKey[bestIdx]) bestIdx = 4'(i);
    end
    secondIdx = (bestIdx == 4'd0) ? 4'd1 : 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(mCount) && 4'(i) != bestIdx && mKey[4'(i)] > mKey[secondIdx]) secondIdx = 4'(i);
    end
    popIdx = (injectOrder && deqNum == 2 && mCount >= 5'd2) ? secondIdx : bestIdx;
  end

  assign kvoKey = mKey[popIdx];
  assign kvoVal = mVal[popIdx] ^ {7'd0, (flipVal && deqNum == 2)};
  assign empty  = stuckNotEmpty ? 1'b0 : (mCount == 5'd0);
  assign full   = (mCount == 5'(DEPTH));

  // Queue contents change on the edge that ends an enq/deq pulse.
  always @(posedge clk) begin
    if (rst) begin
      mCount <= 5'd0;
      deqNum <= 0;
    end else if (enq && deq) begin
      mKey[popIdx] <= kviKey;
      mVal[popIdx] <= kviVal;
      deqNum       <= deqNum + 1;
    end else if (enq) begin
      if (mCount < 5'(DEPTH)) begin
        mKey[mCount[3:0]] <= kviKey;
        mVal[mCount[3:0]] <= kviVal;
        mCount            <= mCount + 5'd1;
      end
    end else if (deq) begin
      if (mCount != 5'd0) begin
        mKey[popIdx] <= mKey[4'(mCount - 5'd1)];
        mVal[popIdx] <= mVal[4'(mCount - 5'd1)];
        mCount       <= mCount - 5'd1;
        deqNum       <= deqNum + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    busy = 1'b0;
    start = 1'b0;
    injectOrder = 1'b0;
    flipVal = 1'b0;
    stuckNotEmpty = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] mix);
    numMix = mix;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(done), 1);
  endtask

  task automatic waitFirstDeq(output int enqBefore);
    int n = 0;
    enqBefore = 0;
    do begin
      @(negedge clk);
      n++;
      if (enq && !deq) enqBefore++;
    end while (!deq && n < 400);
    checkOutput("firstDeqSeen", int'(deq), 1);
  endtask

  typedef struct {
    int         stall;
    logic [7:0] expKey;
    logic [7:0] expVal;
  } fillVec_t;

  fillVec_t vecs [8];

  initial begin
    int n;
    int ops;
    int extraEnq;

    vecs[0] = '{0, 8'hA5, VALUE_CHECK ? 8'hA5 : 8'h00};
    vecs[1] = '{1, 8'hEA, VALUE_CHECK ? 8'hEA : 8'h00};
    vecs[2] = '{3, 8'h75, VALUE_CHECK ? 8'h75 : 8'h00};
    vecs[3] = '{0, 8'h82, VALUE_CHECK ? 8'h82 : 8'h00};
    vecs[4] = '{2, 8'h41, VALUE_CHECK ? 8'h41 : 8'h00};
    vecs[5] = '{0, 8'h98, VALUE_CHECK ? 8'h98 : 8'h00};
    vecs[6] = '{5, 8'h4C, VALUE_CHECK ? 8'h4C : 8'h00};
    vecs[7] = '{1, 8'h26, VALUE_CHECK ? 8'h26 : 8'h00};

    repeat (3) @(negedge clk);
    checkOutput("resetEnq", int'(enq), 0);
    checkOutput("resetDeq", int'(deq), 0);
    checkOutput("resetDone", int'(done), 0);
    checkOutput("resetErr", int'(errCount), 0);
    checkOutput("resetKviKey", int'(kviKey), 0);
    checkOutput("resetKviVal", int'(kviVal), 0);

    // Fill-phase key sequence with busy stalls between enqueues, then the full run.
    doReset();
    applyStimulus(16'd100);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].stall > 0) begin
        ops = 0;
        busy = 1'b1;
        repeat (vecs[i].stall) begin
          @(negedge clk);
          if (enq || deq) ops++;
        end
        busy = 1'b0;
        checkOutput($sformatf("fillStallOps%0d", i), ops, 0);
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!enq && n < 20);
      checkOutput($sformatf("fillEnqSeen%0d", i), int'(enq), 1);
      checkOutput($sformatf("fillKey%0d", i), int'(kviKey), int'(vecs[i].expKey));
      checkOutput($sformatf("fillVal%0d", i), int'(kviVal), int'(vecs[i].expVal));
    end
    waitFirstDeq(extraEnq);
    checkOutput("enqsBeforeFirstDeq", 8 + extraEnq, 8);
    waitDone("fullRunDone");
    checkOutput("fullRunErr", int'(errCount), 0);

    // Reset in the middle of FILL.
    doReset();
    applyStimulus(16'd100);
    n = 0;
    ops = 0;
    while (ops < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (enq) ops++;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetEnq", int'(enq), 0);
    checkOutput("midResetDeq", int'(deq), 0);
    checkOutput("midResetErr", int'(errCount), 0);
    checkOutput("midResetDone", int'(done), 0);
    rst = 1'b0;
    ops = 0;
    repeat (10) begin
      @(negedge clk);
      if (enq || deq) ops++;
    end
    checkOutput("idleAfterResetOps", ops, 0);

    // Busy held for five cycles during the mixed phase.
    doReset();
    applyStimulus(16'd100);
    waitFirstDeq(extraEnq);
    busy = 1'b1;
    ops = 0;
    repeat (5) begin
      @(negedge clk);
      if (enq || deq) ops++;
    end
    busy = 1'b0;
    checkOutput("busyWindowOps", ops, 0);
    waitDone("busyRunDone");
    checkOutput("busyRunErr", int'(errCount), 0);

    // Drain ordering violated once.
    doReset();
    injectOrder = 1'b1;
    applyStimulus(16'd0);
    waitDone("orderRunDone");
    checkOutput("orderRunErr", int'(errCount), 1);

    // Empty flag stuck low, then a clean restart without reset.
    doReset();
    stuckNotEmpty = 1'b1;
    applyStimulus(16'd0);
    waitDone("stuckRunDone");
    checkOutput("stuckRunErrNonzero", int'(errCount != 16'd0), 1);
    stuckNotEmpty = 1'b0;
    applyStimulus(16'd0);
    checkOutput("restartErrCleared", int'(errCount), 0);
    checkOutput("restartDoneCleared", int'(done), 0);
    waitDone("restartRunDone");
    checkOutput("restartRunErr", int'(errCount), 0);

    // One popped value with a corrupted tag.
    doReset();
    flipVal = 1'b1;
    applyStimulus(16'd0);
    waitDone("valueRunDone");
    checkOutput("valueRunErr", int'(errCount), VALUE_CHECK ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
